window_line_buffer: RTL
=======================

# window_line_buffer

Parametrised single-line pixel buffer for the Zynq edge-detection pipeline. It stores one image line of arbitrary length and presents a TAPS-wide horizontal pixel window combinationally from the read pointer. It adds occupancy tracking, full/empty, overflow/underflow flags, selectable border handling, end-of-line pulse and synchronous flush. Three or more instances feed the convolution/control stage, one per image row.

## Interface
Parameters:
- PIXEL_W, 8: bits per pixel.
- LINE_LEN, 512: pixels per line; any value ≥ TAPS, not restricted to a power of two.
- TAPS, 3: window width in pixels; ≥ 1.
- BORDER_MODE, 0: 0 = taps wrap modulo LINE_LEN; 1 = taps clamp to index LINE_LEN-1 (edge replicate).

Ports (clock and reset first):
- in_clk  input  1  clock; one clock domain, all logic on rising edge.
- in_rst  input  1  reset, asynchronous, active-high.
- in_flush  input  1  synchronous clear of pointers, count and flags.
- in_data  input  PIXEL_W  pixel to write.
- in_data_valid  input  1  write request.
- in_read_data  input  1  read-advance request (consume one pixel).
- out_data  output  TAPS*PIXEL_W  window; tap 0 (pixel at read pointer) in MSBs, tap TAPS-1 in LSBs.
- out_fill  output  clog2(LINE_LEN+1)  pixels written and not yet consumed.
- out_full  output  1  out_fill == LINE_LEN.
- out_empty  output  1  out_fill == 0.
- out_line_done  output  1  one-cycle pulse: read pointer wrapped.
- out_overflow  output  1  sticky: write dropped while full.
- out_underflow  output  1  sticky: read ignored while empty.

## Operation
- Storage: LINE_LEN × PIXEL_W register array; contents never reset; combinational read.
- Pointers wp, rp: width clog2(LINE_LEN); increment by 1; LINE_LEN-1 → 0 (explicit compare, not natural overflow).
- Write accepted = in_data_valid && !out_full && !in_flush: mem[wp] ← in_data, wp advances.
- Read accepted = in_read_data && !out_empty && !in_flush: rp advances.
- out_fill: +1 write-only, -1 read-only, unchanged for both or neither. Write+read while full or empty: only the permitted side is accepted.
- Rejected write sets out_overflow; rejected read sets out_underflow. Both clear only on in_rst or in_flush.
- Tap k address = rp+k. BORDER_MODE 0: modulo LINE_LEN. BORDER_MODE 1: min(rp+k, LINE_LEN-1). Intermediate sum is PTR_W+1 bits.
- out_line_done is registered; high the cycle after an accepted read moves rp from LINE_LEN-1 to 0.
- in_flush has priority over all requests. It zeroes wp, rp, out_fill, sticky flags and out_line_done. Memory is untouched.
- Window taps beyond out_fill show stale data. Consumers gate on out_fill ≥ TAPS.

## Timing
- Reset values: wp=rp=0, out_fill=0, out_empty=1, out_full=0, out_line_done=0, out_overflow=0, out_underflow=0. out_data = stale memory (X in sim until written).
- Write-to-visible latency: 1 cycle; pixel written at edge N appears on out_data from edge N onward if addressed.
- Read advance: out_data shifts one pixel combinationally after the edge that accepts the read; zero-latency window.
- out_fill/out_full/out_empty are registered or decoded from registered count; valid the cycle after the request edge.
- Reset mid-operation: asynchronous; all state returns to reset values immediately, with no partial update.

## Structure
- Package window_line_buffer_pkg: BORDER_WRAP=0, BORDER_CLAMP=1 constants; clog2 function; PTR_W/CNT_W derivation helpers.
- Sub-module mod_counter (parameter MOD; inputs clk, rst, clr, inc; output count; wraps MOD-1 → 0; provides wrap strobe). Instantiated twice for wp and rp; the rp wrap strobe drives out_line_done.
- Tap address generation: generate loop over TAPS in top level.

## Test plan
- Reset then write 0x01..0x05 (LINE_LEN=8, TAPS=3) → out_fill=5; out_data=0x010203; three reads → out_data=0x040500 is not checked, fill=2.
- Fill LINE_LEN=8 with 0x10..0x17, extra write 0xFF → write dropped, out_full=1, out_overflow=1, mem[0] still 0x10.
- BORDER_MODE 0, rp=6 after 6 reads on full buffer → out_data=0x161710. BORDER_MODE 1 at same point → 0x161717.
- Simultaneous write+read with fill=4 for 20 cycles → fill stays 4. out_line_done pulses exactly on each rp 7→0 wrap, first at read #8.
- Read on empty → out_underflow=1, rp unchanged. in_flush → all flags 0, fill 0, pointers 0.
- Assert in_rst asynchronously mid-stream (between edges) → outputs reach reset values before the next edge; LINE_LEN=5 non-power-of-two wrap verified 4 → 0.

Source files
------------

// File: rtl/window_line_buffer_pkg.sv
// ---------------------------------------------------------------------------
// window_line_buffer_pkg
// Shared constants and width helpers for the single-line pixel buffer.
//   BORDER_WRAP / BORDER_CLAMP : legal values of the BORDER_MODE parameter
//   clog2(value)               : ceiling log2, usable in constant expressions
//   ptr_w(len)                 : width of a pointer that indexes 0..len-1
//   cnt_w(len)                 : width of a counter that holds 0..len
// ---------------------------------------------------------------------------
package window_line_buffer_pkg;

  localparam int BORDER_WRAP  = 0;
  localparam int BORDER_CLAMP = 1;

  // Smallest r such that 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // A pointer is never narrower than one bit, even for a one-entry line.
  function automatic int ptr_w(input int len);
    return (len > 1) ? clog2(len) : 1;
  endfunction

  // The fill count must represent the full state, hence len+1 values.
  function automatic int cnt_w(input int len);
    return clog2(len + 1);
  endfunction

endpackage

// File: rtl/window_line_buffer_mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
// Modulo-MOD up-counter used for the line buffer's write and read pointers.
// Wraps explicitly from MOD-1 to 0, so MOD need not be a power of two.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset (count and wrap to 0)
//   clr   : synchronous clear, dominates inc
//   inc   : advance the count by one
//   count : current count, 0..MOD-1
//   wrap  : registered strobe, high for one cycle after a MOD-1 -> 0 step
// ---------------------------------------------------------------------------
module mod_counter
  import window_line_buffer_pkg::*;
#(
  parameter  int MOD = 8,
  localparam int W   = ptr_w(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;

  // Next count and wrap strobe; the strobe only lives for the cycle that
  // follows the wrapping increment.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      if (count_q == W'(MOD - 1)) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  // Count and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: rtl/window_line_buffer.sv
// ---------------------------------------------------------------------------
// window_line_buffer
// Stores one image line and presents a TAPS-wide horizontal window starting
// at the read pointer, with occupancy tracking and sticky error flags.
//   in_clk, in_rst   : clock, asynchronous active-high reset
//   in_flush         : synchronous clear of pointers, count and flags
//   in_data          : pixel to write
//   in_data_valid    : write request (dropped while full)
//   in_read_data     : consume one pixel (ignored while empty)
//   out_data         : window, tap 0 (pixel at read pointer) in the MSBs
//   out_fill         : pixels written and not yet consumed
//   out_full/empty   : decoded from out_fill
//   out_line_done    : one-cycle pulse after the read pointer wraps to 0
//   out_overflow     : sticky, a write was dropped while full
//   out_underflow    : sticky, a read was ignored while empty
// ---------------------------------------------------------------------------
module window_line_buffer
  import window_line_buffer_pkg::*;
#(
  parameter  int PIXEL_W     = 8,
  parameter  int LINE_LEN    = 512,
  parameter  int TAPS        = 3,
  parameter  int BORDER_MODE = BORDER_WRAP,
  localparam int PTR_W       = ptr_w(LINE_LEN),
  localparam int CNT_W       = cnt_w(LINE_LEN)
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_flush,
  input  logic [PIXEL_W-1:0]      in_data,
  input  logic                    in_data_valid,
  input  logic                    in_read_data,
  output logic [TAPS*PIXEL_W-1:0] out_data,
  output logic [CNT_W-1:0]        out_fill,
  output logic                    out_full,
  output logic                    out_empty,
  output logic                    out_line_done,
  output logic                    out_overflow,
  output logic                    out_underflow
);

  // Tap sums need one extra bit so rp+k never overflows before folding.
  localparam int SUM_W = PTR_W + 1;

  logic [PIXEL_W-1:0] mem_q [LINE_LEN];

  logic [CNT_W-1:0] fill_q, fill_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic             wrAccept;
  logic             rdAccept;
  logic             rpWrap;
  logic             unusedWpWrap;

  assign out_full  = (fill_q == CNT_W'(LINE_LEN));
  assign out_empty = (fill_q == '0);

  // Flush blocks both sides so it wins over any simultaneous request.
  assign wrAccept = in_data_valid && !out_full  && !in_flush;
  assign rdAccept = in_read_data  && !out_empty && !in_flush;

  mod_counter #(.MOD(LINE_LEN)) uWritePtr (
    .clk   (in_clk),
    .rst   (in_rst),
    .clr   (in_flush),
    .inc   (wrAccept),
    .count (wp),
    .wrap  (unusedWpWrap)
  );

  mod_counter #(.MOD(LINE_LEN)) uReadPtr (
    .clk   (in_clk),
    .rst   (in_rst),
    .clr   (in_flush),
    .inc   (rdAccept),
    .count (rp),
    .wrap  (rpWrap)
  );

  // Pixel storage; deliberately has no reset so it maps onto plain flops
  // or distributed RAM, and a flush leaves the line contents in place.
  always_ff @(posedge in_clk) begin
    if (wrAccept) begin
      mem_q[wp] <= in_data;
    end
  end

  // Occupancy and sticky flags. A write and a read in the same cycle
  // cancel out; a rejected side still raises its sticky flag.
  always_comb begin
    fill_d      = fill_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (in_flush) begin
      fill_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wrAccept && !rdAccept) begin
        fill_d = fill_q + CNT_W'(1);
      end else if (rdAccept && !wrAccept) begin
        fill_d = fill_q - CNT_W'(1);
      end
      if (in_data_valid && !wrAccept) begin
        overflow_d = 1'b1;
      end
      if (in_read_data && !rdAccept) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      fill_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // One address per tap. Because TAPS <= LINE_LEN and rp < LINE_LEN, the
  // sum is below 2*LINE_LEN, so a single conditional subtract is a full
  // modulo; clamping replicates the last pixel of the line instead.
  for (genvar k = 0; k < TAPS; k++) begin : gTap
    logic [SUM_W-1:0] tapSum;
    logic [PTR_W-1:0] tapAddr;

    always_comb begin
      tapSum = {1'b0, rp} + SUM_W'(k);
      if (BORDER_MODE == BORDER_CLAMP) begin
        if (tapSum > SUM_W'(LINE_LEN - 1)) begin
          tapAddr = PTR_W'(LINE_LEN - 1);
        end else begin
          tapAddr = PTR_W'(tapSum);
        end
      end else begin
        if (tapSum >= SUM_W'(LINE_LEN)) begin
          tapAddr = PTR_W'(tapSum - SUM_W'(LINE_LEN));
        end else begin
          tapAddr = PTR_W'(tapSum);
        end
      end
    end

    assign out_data[(TAPS-1-k)*PIXEL_W +: PIXEL_W] = mem_q[tapAddr];
  end

  assign out_fill      = fill_q;
  assign out_overflow  = overflow_q;
  assign out_underflow = underflow_q;
  assign out_line_done = rpWrap;

endmodule
